frac_clken_gen: RTL and testbench

FRAC_CLKEN_GEN -- requirements
Module: frac_clken_gen

---
 rtl/frac_clken_gen.sv | 90 +++++++++
 tb/tb_frac_clken_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_clken_gen.sv
// Fractional clock-enable generator.
// Each channel runs a phase accumulator; the carry out of acc + inc becomes a
// one-cycle tick, and sq_out toggles on every tick. Increment updates are
// staged in a shadow register and applied on a carry edge so the output phase
// stays continuous across frequency changes.
module frac_clken_gen #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 24,
    parameter logic [ACC_W-1:0] DEFAULT_INC = 24'h333333,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] run,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq_out
);

    logic [ACC_W-1:0]  acc    [NUM_CH];
    logic [ACC_W-1:0]  inc    [NUM_CH];
    logic [ACC_W-1:0]  shadow [NUM_CH];
    logic [ACC_W:0]    sum    [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] run_d;
    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] cfg_wr;

    // Address decode; an out-of-range channel hits nothing, so it reads ready
    // and the write falls on the floor.
    always_comb begin
        ch_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                ch_hit[i] = 1'b1;
            end
        end
        cfg_ready = ~|(ch_hit & pending);
        cfg_wr    = (cfg_valid ? ch_hit : '0) & ~pending;
    end

    // Per-channel (ACC_W+1)-bit sum; the top bit is the carry that makes a tick.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    // Accumulator, tick/square outputs and the shadow-increment handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]    <= '0;
                inc[i]    <= DEFAULT_INC;
                shadow[i] <= DEFAULT_INC;
            end
            pending <= '0;
            run_d   <= '0;
            tick    <= '0;
            sq_out  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                run_d[i] <= run[i];
                tick[i]  <= 1'b0;
                if (run[i] && run_d[i]) begin
                    acc[i]  <= sum[i][ACC_W-1:0];
                    tick[i] <= sum[i][ACC_W];
                    if (sum[i][ACC_W]) begin
                        sq_out[i] <= ~sq_out[i];
                    end
                end else if (run[i]) begin
                    // Rising run: restart from phase zero, first add happens next edge.
                    acc[i] <= '0;
                end
                // The add on the applying edge still uses the old increment.
                if (pending[i] && (!run[i] || (run_d[i] && sum[i][ACC_W]))) begin
                    inc[i]     <= shadow[i];
                    pending[i] <= 1'b0;
                end else if (cfg_wr[i]) begin
                    shadow[i]  <= cfg_inc;
                    pending[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frac_clken_gen.sv
// Directed bench for frac_clken_gen with NUM_CH=3, ACC_W=4, reset increment 4.
module tb_frac_clken_gen;

    logic       clk;
    logic       rst;
    logic [2:0] run;
    logic       cfg_valid;
    logic [1:0] cfg_ch;
    logic [3:0] cfg_inc;
    logic       cfg_ready;
    logic [2:0] tick;
    logic [2:0] sq_out;

    int n_pass;
    int n_total;

    frac_clken_gen #(
        .NUM_CH(3),
        .ACC_W(4),
        .DEFAULT_INC(4'h4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .cfg_valid(cfg_valid),
        .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc),
        .cfg_ready(cfg_ready),
        .tick(tick),
        .sq_out(sq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = '0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_inc = '0;
        #2;
        n_total++;
        if (tick !== 3'b000) $display("FAIL reset_tick got %b want 000", tick);
        else n_pass++;
        n_total++;
        if (sq_out !== 3'b000) $display("FAIL reset_sq got %b want 000", sq_out);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            cfg_ch = 2'(c);
            #1;
            n_total++;
            if (cfg_ready !== 1'b1) $display("FAIL reset_ready ch%0d got %b want 1", c, cfg_ready);
            else n_pass++;
        end
        step(); step();
        rst = 1'b0;
        step();
    endtask

    // default inc=4: clear edge, then tick on edge 5, 9, 13...
    task automatic test_inc4();
        logic exp_t;
        logic exp_sq;
        exp_sq = 1'b0;
        run = 3'b001;
        for (int e = 1; e <= 21; e++) begin
            step();
            exp_t = (e >= 5) && ((e - 5) % 4 == 0);
            if (exp_t) exp_sq = ~exp_sq;
            n_total++;
            if ({tick[0], sq_out[0]} !== {exp_t, exp_sq})
                $display("FAIL inc4_edge%0d got tick=%b sq=%b want tick=%b sq=%b", e, tick[0], sq_out[0], exp_t, exp_sq);
            else n_pass++;
        end
        run = 3'b000;
        for (int e = 1; e <= 3; e++) begin
            step();
            n_total++;
            if ({tick[0], sq_out[0]} !== {1'b0, 1'b1})
                $display("FAIL stop_hold%0d got tick=%b sq=%b want tick=0 sq=1", e, tick[0], sq_out[0]);
            else n_pass++;
        end
    endtask

    // ch1 set to inc=6 while stopped, then 800 cycles of the 3-in-8 pattern
    task automatic test_inc6();
        int errs;
        int ticks;
        logic exp_t;
        cfg_ch = 2'd1; cfg_inc = 4'd6; cfg_valid = 1'b1;
        #1;
        n_total++;
        if (cfg_ready !== 1'b1) $display("FAIL inc6_ready_pre got %b want 1", cfg_ready);
        else n_pass++;
        step();
        cfg_valid = 1'b0;
        n_total++;
        if (cfg_ready !== 1'b0) $display("FAIL inc6_ready_pending got %b want 0", cfg_ready);
        else n_pass++;
        step();
        n_total++;
        if (cfg_ready !== 1'b1) $display("FAIL inc6_ready_applied got %b want 1", cfg_ready);
        else n_pass++;
        run = 3'b010;
        step();
        errs = 0; ticks = 0;
        for (int k = 1; k <= 800; k++) begin
            step();
            exp_t = (k % 8 == 3) || (k % 8 == 6) || (k % 8 == 0);
            if (tick[1] !== exp_t || tick[0] !== 1'b0) errs++;
            if (tick[1] === 1'b1) ticks++;
        end
        n_total++;
        if (errs !== 0) $display("FAIL inc6_pattern got %0d bad edges want 0", errs);
        else n_pass++;
        n_total++;
        if (ticks !== 300) $display("FAIL inc6_count got %0d ticks want 300", ticks);
        else n_pass++;
        run = 3'b000;
        step();
    endtask

    // running ch0 inc=4 -> 8, applied on the next carry; a write during pending is dropped
    task automatic test_update();
        logic exp_t;
        run = 3'b001;
        for (int e = 1; e <= 11; e++) begin
            if (e == 3) begin
                cfg_ch = 2'd0; cfg_inc = 4'd8; cfg_valid = 1'b1;
                #1;
                n_total++;
                if (cfg_ready !== 1'b1) $display("FAIL upd_ready_pre got %b want 1", cfg_ready);
                else n_pass++;
            end
            if (e == 4) cfg_inc = 4'd1;
            if (e == 6) cfg_valid = 1'b0;
            step();
            exp_t = (e >= 5) && (e % 2 == 1);
            n_total++;
            if (tick[0] !== exp_t) $display("FAIL upd_tick_edge%0d got %b want %b", e, tick[0], exp_t);
            else n_pass++;
            if (e == 3 || e == 4) begin
                n_total++;
                if (cfg_ready !== 1'b0) $display("FAIL upd_ready_edge%0d got %b want 0", e, cfg_ready);
                else n_pass++;
            end
            if (e == 5) begin
                n_total++;
                if (cfg_ready !== 1'b1) $display("FAIL upd_ready_edge5 got %b want 1", cfg_ready);
                else n_pass++;
            end
        end
    endtask

    // ch1 stopped: write inc=2 applies next edge while ch0 keeps ticking every 2
    task automatic test_independent();
        cfg_ch = 2'd1; cfg_inc = 4'd2; cfg_valid = 1'b1;
        #1;
        n_total++;
        if (cfg_ready !== 1'b1) $display("FAIL ind_ready_pre got %b want 1", cfg_ready);
        else n_pass++;
        for (int n = 1; n <= 6; n++) begin
            step();
            cfg_valid = 1'b0;
            n_total++;
            if (tick[1:0] !== {1'b0, (n % 2 == 0)})
                $display("FAIL ind_tick_edge%0d got %b want %b", n, tick[1:0], {1'b0, (n % 2 == 0)});
            else n_pass++;
            if (n <= 2) begin
                n_total++;
                if (cfg_ready !== (n == 2)) $display("FAIL ind_ready_edge%0d got %b want %b", n, cfg_ready, (n == 2));
                else n_pass++;
            end
        end
        run = 3'b011;
        for (int m = 1; m <= 12; m++) begin
            step();
            n_total++;
            if (tick[1] !== (m == 9)) $display("FAIL ind_ch1_edge%0d got %b want %b", m, tick[1], (m == 9));
            else n_pass++;
        end
    endtask

    // out-of-range channel write is ignored; inc=0 never ticks
    task automatic test_bad_ch_zero();
        int t0;
        int t1;
        int t2;
        cfg_ch = 2'd3; cfg_inc = 4'd0; cfg_valid = 1'b1;
        #1;
        n_total++;
        if (cfg_ready !== 1'b1) $display("FAIL bad_ready got %b want 1", cfg_ready);
        else n_pass++;
        step();
        cfg_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cfg_ch = 2'(c);
            #1;
            n_total++;
            if (cfg_ready !== 1'b1) $display("FAIL bad_no_pending ch%0d got %b want 1", c, cfg_ready);
            else n_pass++;
        end
        t0 = 0; t1 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (tick[0] === 1'b1) t0++;
            if (tick[1] === 1'b1) t1++;
        end
        n_total++;
        if (t0 !== 8) $display("FAIL bad_ch0_rate got %0d ticks want 8", t0);
        else n_pass++;
        n_total++;
        if (t1 !== 2) $display("FAIL bad_ch1_rate got %0d ticks want 2", t1);
        else n_pass++;
        cfg_ch = 2'd2; cfg_inc = 4'd0; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        run = 3'b111;
        t2 = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (tick[2] === 1'b1) t2++;
        end
        n_total++;
        if (t2 !== 0) $display("FAIL zero_inc got %0d ticks want 0", t2);
        else n_pass++;
        n_total++;
        if (sq_out[2] !== 1'b0) $display("FAIL zero_inc_sq got %b want 0", sq_out[2]);
        else n_pass++;
        run = 3'b001;
    endtask

    // reset during a pending write with sq_out high, then restart at default inc
    task automatic test_reset_mid();
        logic found;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tick[0] === 1'b1 && sq_out[0] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_total++;
        if (found !== 1'b1) $display("FAIL rmid_find_sq got %b want 1", found);
        else n_pass++;
        cfg_ch = 2'd0; cfg_inc = 4'd1; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        n_total++;
        if ({sq_out[0], cfg_ready} !== 2'b10)
            $display("FAIL rmid_pre got sq=%b ready=%b want sq=1 ready=0", sq_out[0], cfg_ready);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({sq_out, tick, cfg_ready} !== 7'b000_000_1)
            $display("FAIL rmid_async got sq=%b tick=%b ready=%b want sq=000 tick=000 ready=1", sq_out, tick, cfg_ready);
        else n_pass++;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            n_total++;
            if (tick[0] !== (e == 5 || e == 9))
                $display("FAIL rmid_restart_edge%0d got %b want %b", e, tick[0], (e == 5 || e == 9));
            else n_pass++;
        end
        n_total++;
        if (cfg_ready !== 1'b1) $display("FAIL rmid_ready_after got %b want 1", cfg_ready);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_inc4();
        test_inc6();
        test_update();
        test_independent();
        test_bad_ch_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
